// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART.
// Enumerators carry a Tx/Rx prefix so both state types can live in one package.
package uart_pkg;

  typedef enum int unsigned {
    PAR_NONE = 0,
    PAR_EVEN = 1,
    PAR_ODD  = 2
  } parity_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  // Total bits on the wire for one frame: start + payload + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 32'd1 + data_bits + ((parity != PAR_NONE) ? 32'd1 : 32'd0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM with start-bit glitch
// rejection, and sticky ready plus per-frame error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] BitEnd   = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] HalfEnd  = CntW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam bit HasPar = (PARITY != PAR_NONE);
  localparam bit OddPar = (PARITY == PAR_ODD);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 rx_s, done, par_mismatch;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RxIdle;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rx};
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = RxStart;
      end
      RxStart: begin
        // Line back high by mid-start-bit means a glitch, not a frame.
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastData) state_d = HasPar ? RxParity : RxStop;
        end
      end
      RxParity: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_comb begin
    done         = (state_q == RxStop) && (cnt_q == BitEnd);
    par_mismatch = HasPar && ((^shreg_q ^ par_bit_q) != OddPar);
  end

  // Frame completion beats a concurrent ready_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (done) begin
      ready      <= 1'b1;
      data_out   <= shreg_q;
      parity_err <= par_mismatch;
      frame_err  <= ~rx_s;
    end else if (ready_clr) begin
      ready      <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART top: inline TX FSM with registered outputs,
// receiver delegated to uart_rx_core.
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_PULSE * STOP_BITS);
  localparam int unsigned BitW = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS) + 1);
  localparam logic [CntW-1:0] BitEnd   = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] StopEnd  = CntW'(CLOCKS_PER_PULSE * STOP_BITS - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam bit HasPar = (PARITY != PAR_NONE);
  localparam bit OddPar = (PARITY == PAR_ODD);

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, busy_q, busy_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    unique case (state_q)
      TxIdle: begin
        cnt_d = '0;
        if (data_en) begin
          state_d = TxStart;
          shreg_d = data_in;
          par_d   = OddPar ? ~(^data_in) : ^data_in;
        end
      end
      TxStart: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TxData;
        end
      end
      TxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastData) state_d = HasPar ? TxParity : TxStop;
        end
      end
      TxParity: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          state_d = TxStop;
        end
      end
      TxStop: begin
        if (cnt_q == StopEnd) begin
          cnt_d   = '0;
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins track the FSM edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_d)
      TxIdle:   busy_d = 1'b0;
      TxStart:  tx_d = 1'b0;
      TxData:   tx_d = shreg_d[0];
      TxParity: tx_d = par_d;
      TxStop:   tx_d = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

  uart_rx_core #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .DATA_BITS       (DATA_BITS),
    .PARITY          (PARITY)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .ready_clr (ready_clr),
    .ready     (ready),
    .data_out  (data_out),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

endmodule
